// File: rtl/frog_pkg.sv
// rtl/frog_pkg.sv - shared state codes, lane constants and lane-move helper
package frog_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] HIT  = 2'd2;
  localparam logic [1:0] OVER = 2'd3;

  localparam logic [2:0] LANE_L = 3'b100;
  localparam logic [2:0] LANE_M = 3'b010;
  localparam logic [2:0] LANE_R = 3'b001;

  // One-lane move; simultaneous presses cancel and the outer lanes are walls
  function automatic logic [2:0] lane_step(input logic [2:0] pos,
                                           input logic go_l,
                                           input logic go_r);
    logic [2:0] nxt;
    nxt = pos;
    if (go_l && !go_r && pos != LANE_L) begin
      nxt = {pos[1:0], 1'b0};
    end else if (go_r && !go_l && pos != LANE_R) begin
      nxt = {1'b0, pos[2:1]};
    end
    return nxt;
  endfunction

endpackage

// File: rtl/key_press.sv
// rtl/key_press.sv - two-flop synchronizer plus single-cycle press pulse
module key_press (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic press
);

  logic sync0_q, sync0_d;
  logic sync1_q, sync1_d;
  logic prev_q, prev_d;

  // Shift the raw key through the synchronizer and remember the last synced level
  always_comb begin
    sync0_d = key_raw;
    sync1_d = sync0_q;
    prev_d  = sync1_q;
  end

  // Register the synchronizer chain
  always_ff @(posedge clk) begin
    if (reset) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync0_q <= sync0_d;
      sync1_q <= sync1_d;
      prev_q  <= prev_d;
    end
  end

  // A press is the first cycle the synced level is high, so a held key moves once
  assign press = sync1_q & ~prev_q;

endmodule

// File: rtl/frog_hop_ctrl.sv
// rtl/frog_hop_ctrl.sv - frog lane tracking, collision check, lives/score FSM
module frog_hop_ctrl
  import frog_pkg::*;
#(
  parameter int LIVES     = 3,
  parameter int LIFE_W    = 2,
  parameter int SCORE_W   = 8,
  parameter int HIT_TICKS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               key_l,
  input  logic               key_r,
  input  logic               tick,
  input  logic [2:0]         pattern,
  output logic [2:0]         frog_pos,
  output logic [LIFE_W-1:0]  lives,
  output logic [SCORE_W-1:0] score,
  output logic               playing,
  output logic               game_over
);

  localparam int COOL_W = $clog2(HIT_TICKS + 1);

  localparam logic [LIFE_W-1:0]  LIVES_INIT = LIFE_W'(LIVES);
  localparam logic [LIFE_W-1:0]  LIFE_ONE   = LIFE_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
  localparam logic [COOL_W-1:0]  COOL_INIT  = COOL_W'(HIT_TICKS);
  localparam logic [COOL_W-1:0]  COOL_ONE   = COOL_W'(1);

  logic press_l, press_r;

  logic [1:0]         state_q, state_d;
  logic [2:0]         frog_q, frog_d;
  logic [LIFE_W-1:0]  lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [COOL_W-1:0]  cool_q, cool_d;
  logic               playing_q, playing_d;
  logic               over_q, over_d;
  logic               collide;

  key_press u_key_l (
    .clk     (clk),
    .reset   (reset),
    .key_raw (key_l),
    .press   (press_l)
  );

  key_press u_key_r (
    .clk     (clk),
    .reset   (reset),
    .key_raw (key_r),
    .press   (press_r)
  );

  // Game FSM: load on start, step lives/score/cooldown on tick, move on presses
  always_comb begin
    state_d = state_q;
    frog_d  = frog_q;
    lives_d = lives_q;
    score_d = score_q;
    cool_d  = cool_q;
    // Collision uses the lane the frog occupied before any move this cycle
    collide = |(frog_q & pattern);

    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d = PLAY;
          lives_d = LIVES_INIT;
          score_d = '0;
          frog_d  = LANE_M;
          cool_d  = '0;
        end
      end
      PLAY: begin
        frog_d = lane_step(frog_q, press_l, press_r);
        if (tick) begin
          if (collide) begin
            if (lives_q == LIFE_ONE) begin
              lives_d = '0;
              state_d = OVER;
            end else begin
              lives_d = lives_q - LIFE_ONE;
              state_d = HIT;
              cool_d  = COOL_INIT;
            end
          end else if (score_q != SCORE_MAX) begin
            score_d = score_q + SCORE_ONE;
          end
        end
      end
      HIT: begin
        frog_d = lane_step(frog_q, press_l, press_r);
        if (tick) begin
          if (cool_q == COOL_ONE) begin
            state_d = PLAY;
          end else begin
            cool_d = cool_q - COOL_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    playing_d = (state_d == PLAY) || (state_d == HIT);
    over_d    = (state_d == OVER);
  end

  // Register game state and the decoded status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      frog_q    <= LANE_M;
      lives_q   <= '0;
      score_q   <= '0;
      cool_q    <= '0;
      playing_q <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      frog_q    <= frog_d;
      lives_q   <= lives_d;
      score_q   <= score_d;
      cool_q    <= cool_d;
      playing_q <= playing_d;
      over_q    <= over_d;
    end
  end

  assign frog_pos  = frog_q;
  assign lives     = lives_q;
  assign score     = score_q;
  assign playing   = playing_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_frog_hop_ctrl.sv
// tb/tb_frog_hop_ctrl.sv - table vectors plus randomized run against a game model
module tb_frog_hop_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       key_l = 1'b0;
  logic       key_r = 1'b0;
  logic       tick = 1'b0;
  logic [2:0] pattern = 3'b000;
  logic [2:0] frog_pos;
  logic [1:0] lives;
  logic [7:0] score;
  logic       playing;
  logic       game_over;

  int total = 0;
  int passed = 0;

  frog_hop_ctrl #(
    .LIVES     (3),
    .LIFE_W    (2),
    .SCORE_W   (8),
    .HIT_TICKS (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .key_l     (key_l),
    .key_r     (key_r),
    .tick      (tick),
    .pattern   (pattern),
    .frog_pos  (frog_pos),
    .lives     (lives),
    .score     (score),
    .playing   (playing),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  // Game model: lane as an index (0 right, 2 left), mode, plain integer counters
  typedef enum {M_IDLE, M_PLAY, M_HIT, M_OVER} mode_t;
  mode_t m_mode = M_IDLE;
  int    m_lane = 1;
  int    m_lives = 0;
  int    m_score = 0;
  int    m_cool = 0;
  logic  hl [3];
  logic  hr [3];

  // A raw key level seen at edge n becomes a move at edge n+2 if it was a rising level
  task automatic model_step(input logic rs, st, kl, kr, tk, input logic [2:0] pat);
    logic pl, pr;
    int   old_lane;
    if (rs) begin
      m_mode = M_IDLE; m_lane = 1; m_lives = 0; m_score = 0; m_cool = 0;
      for (int i = 0; i < 3; i++) begin hl[i] = 1'b0; hr[i] = 1'b0; end
      return;
    end
    pl = hl[1] & ~hl[2];
    pr = hr[1] & ~hr[2];
    hl[2] = hl[1]; hl[1] = hl[0]; hl[0] = kl;
    hr[2] = hr[1]; hr[1] = hr[0]; hr[0] = kr;
    old_lane = m_lane;
    if (m_mode == M_IDLE || m_mode == M_OVER) begin
      if (st) begin
        m_mode = M_PLAY; m_lives = 3; m_score = 0; m_lane = 1;
      end
      return;
    end
    if (pl && !pr && m_lane < 2) m_lane = m_lane + 1;
    if (pr && !pl && m_lane > 0) m_lane = m_lane - 1;
    if (!tk) return;
    if (m_mode == M_PLAY) begin
      if (pat[old_lane]) begin
        m_lives = m_lives - 1;
        if (m_lives == 0) m_mode = M_OVER;
        else begin m_mode = M_HIT; m_cool = 4; end
      end else if (m_score < 255) begin
        m_score = m_score + 1;
      end
    end else begin
      if (m_cool == 1) m_mode = M_PLAY;
      else m_cool = m_cool - 1;
    end
  endtask

  task automatic step(input logic rs, st, kl, kr, tk, input logic [2:0] pat);
    reset = rs; start = st; key_l = kl; key_r = kr; tick = tk; pattern = pat;
    @(posedge clk);
    model_step(rs, st, kl, kr, tk, pat);
    #1;
  endtask

  task automatic check(input string nm, input logic [2:0] ef, input int el, input int es,
                       input logic ep, input logic eo);
    total++;
    if ({frog_pos, lives, score, playing, game_over} === {ef, 2'(el), 8'(es), ep, eo}) begin
      passed++;
    end else begin
      $display("FAIL %s: got frog=%b lives=%0d score=%0d playing=%b over=%b, want frog=%b lives=%0d score=%0d playing=%b over=%b",
               nm, frog_pos, lives, score, playing, game_over, ef, el, es, ep, eo);
    end
  endtask

  typedef struct {
    int         rep;
    logic       rs, st, kl, kr, tk;
    logic [2:0] pat;
    logic       chk;
    logic [2:0] ef;
    int         el, es;
    logic       ep, eo;
    string      nm;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int rep, logic rs, st, kl, kr, tk, logic [2:0] pat, logic chk,
                              logic [2:0] ef, int el, int es, logic ep, eo, string nm);
    vec_t v;
    v.rep = rep; v.rs = rs; v.st = st; v.kl = kl; v.kr = kr; v.tk = tk; v.pat = pat;
    v.chk = chk; v.ef = ef; v.el = el; v.es = es; v.ep = ep; v.eo = eo; v.nm = nm;
    return v;
  endfunction

  initial begin
    logic rkl, rkr;
    //                 rep rs st kl kr tk pat   chk  frog  lv sc  pl ov
    tbl.push_back(mk(1,   1, 0, 0, 0, 0, 3'b000, 1, 3'b010, 0, 0,   0, 0, "reset"));
    tbl.push_back(mk(1,   0, 1, 0, 0, 0, 3'b000, 1, 3'b010, 3, 0,   1, 0, "start"));
    tbl.push_back(mk(2,   0, 0, 1, 0, 0, 3'b000, 1, 3'b010, 3, 0,   1, 0, "key_l_latency"));
    tbl.push_back(mk(1,   0, 0, 1, 0, 0, 3'b000, 1, 3'b100, 3, 0,   1, 0, "key_l_third_edge"));
    tbl.push_back(mk(7,   0, 0, 1, 0, 0, 3'b000, 1, 3'b100, 3, 0,   1, 0, "key_l_held_once"));
    tbl.push_back(mk(3,   0, 0, 0, 0, 0, 3'b000, 0, 3'b100, 0, 0,   0, 0, ""));
    tbl.push_back(mk(3,   0, 0, 1, 0, 0, 3'b000, 1, 3'b100, 3, 0,   1, 0, "key_l_wall"));
    tbl.push_back(mk(2,   0, 0, 0, 0, 0, 3'b000, 0, 3'b100, 0, 0,   0, 0, ""));
    tbl.push_back(mk(1,   0, 0, 0, 1, 0, 3'b000, 0, 3'b100, 0, 0,   0, 0, ""));
    tbl.push_back(mk(2,   0, 0, 0, 0, 0, 3'b000, 1, 3'b010, 3, 0,   1, 0, "key_r_first"));
    tbl.push_back(mk(1,   0, 0, 0, 1, 0, 3'b000, 0, 3'b100, 0, 0,   0, 0, ""));
    tbl.push_back(mk(2,   0, 0, 0, 0, 0, 3'b000, 1, 3'b001, 3, 0,   1, 0, "key_r_second"));
    tbl.push_back(mk(1,   0, 0, 0, 1, 0, 3'b000, 0, 3'b100, 0, 0,   0, 0, ""));
    tbl.push_back(mk(2,   0, 0, 0, 0, 0, 3'b000, 1, 3'b001, 3, 0,   1, 0, "key_r_wall"));
    tbl.push_back(mk(1,   0, 0, 1, 0, 0, 3'b000, 0, 3'b100, 0, 0,   0, 0, ""));
    tbl.push_back(mk(2,   0, 0, 0, 0, 0, 3'b000, 1, 3'b010, 3, 0,   1, 0, "back_to_middle"));
    tbl.push_back(mk(5,   0, 0, 0, 0, 1, 3'b101, 1, 3'b010, 3, 5,   1, 0, "safe_ticks"));
    tbl.push_back(mk(3,   0, 0, 0, 0, 0, 3'b111, 1, 3'b010, 3, 5,   1, 0, "no_tick_no_hit"));
    tbl.push_back(mk(250, 0, 0, 0, 0, 1, 3'b000, 1, 3'b010, 3, 255, 1, 0, "score_to_max"));
    tbl.push_back(mk(1,   0, 0, 0, 0, 1, 3'b101, 1, 3'b010, 3, 255, 1, 0, "score_saturate"));
    tbl.push_back(mk(1,   0, 0, 0, 0, 1, 3'b010, 1, 3'b010, 2, 255, 1, 0, "first_hit"));
    tbl.push_back(mk(3,   0, 0, 0, 0, 1, 3'b010, 1, 3'b010, 2, 255, 1, 0, "hit_invulnerable"));
    tbl.push_back(mk(1,   0, 0, 0, 0, 1, 3'b000, 1, 3'b010, 2, 255, 1, 0, "cooldown_end"));
    tbl.push_back(mk(1,   0, 0, 0, 0, 1, 3'b010, 1, 3'b010, 1, 255, 1, 0, "second_hit"));
    tbl.push_back(mk(4,   0, 0, 0, 0, 1, 3'b010, 1, 3'b010, 1, 255, 1, 0, "second_cooldown"));
    tbl.push_back(mk(1,   0, 0, 0, 0, 1, 3'b010, 1, 3'b010, 0, 255, 0, 1, "game_over"));
    tbl.push_back(mk(3,   0, 0, 1, 0, 0, 3'b000, 0, 3'b100, 0, 0,   0, 0, ""));
    tbl.push_back(mk(2,   0, 0, 0, 1, 1, 3'b111, 0, 3'b100, 0, 0,   0, 0, ""));
    tbl.push_back(mk(3,   0, 0, 0, 0, 1, 3'b111, 1, 3'b010, 0, 255, 0, 1, "over_frozen"));
    tbl.push_back(mk(1,   0, 1, 0, 0, 0, 3'b000, 1, 3'b010, 3, 0,   1, 0, "restart"));
    tbl.push_back(mk(1,   0, 0, 1, 0, 0, 3'b000, 0, 3'b100, 0, 0,   0, 0, ""));
    tbl.push_back(mk(1,   0, 0, 0, 0, 0, 3'b000, 0, 3'b100, 0, 0,   0, 0, ""));
    tbl.push_back(mk(1,   0, 0, 0, 0, 1, 3'b100, 1, 3'b100, 3, 1,   1, 0, "move_with_tick"));
    tbl.push_back(mk(1,   0, 0, 0, 0, 1, 3'b100, 1, 3'b100, 2, 1,   1, 0, "hit_left_lane"));
    tbl.push_back(mk(1,   1, 0, 0, 0, 0, 3'b000, 1, 3'b010, 0, 0,   0, 0, "reset_mid_hit"));
    tbl.push_back(mk(1,   0, 0, 0, 0, 1, 3'b111, 1, 3'b010, 0, 0,   0, 0, "idle_ignores_tick"));
    tbl.push_back(mk(1,   0, 1, 0, 0, 0, 3'b000, 1, 3'b010, 3, 0,   1, 0, "start_after_reset"));
    tbl.push_back(mk(1,   0, 0, 1, 1, 0, 3'b000, 0, 3'b100, 0, 0,   0, 0, ""));
    tbl.push_back(mk(2,   0, 0, 0, 0, 0, 3'b000, 1, 3'b010, 3, 0,   1, 0, "both_keys_no_move"));

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].rep; r++) begin
        step(tbl[i].rs, tbl[i].st, tbl[i].kl, tbl[i].kr, tbl[i].tk, tbl[i].pat);
      end
      if (tbl[i].chk) check(tbl[i].nm, tbl[i].ef, tbl[i].el, tbl[i].es, tbl[i].ep, tbl[i].eo);
    end

    // Randomized play: keys change level occasionally so presses and holds both occur
    rkl = 1'b0;
    rkr = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) rkl = ~rkl;
      if ($urandom_range(0, 3) == 0) rkr = ~rkr;
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 39) == 0), rkl, rkr,
           ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)));
      check("random_vs_model", 3'(1 << m_lane), m_lives, m_score,
            (m_mode == M_PLAY || m_mode == M_HIT), (m_mode == M_OVER));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
